// File: rtl/unidade_muldiv_if.sv
// Request/write-back bundle between the issue stage, the multiply/divide unit and the register file.
// master = issuing side, slave = unidade_muldiv.
interface unidade_muldiv_if;
    logic        inicio;
    logic [2:0]  funct3;
    logic [4:0]  endereco_rd;
    logic [31:0] operando1;
    logic [31:0] operando2;
    logic        ocupado;
    logic        pronto;
    logic        reg_escrita;
    logic [4:0]  endereco_regd;
    logic [31:0] dado_escrita;

    modport master (
        output inicio, funct3, endereco_rd, operando1, operando2,
        input  ocupado, pronto, reg_escrita, endereco_regd, dado_escrita
    );

    modport slave (
        input  inicio, funct3, endereco_rd, operando1, operando2,
        output ocupado, pronto, reg_escrita, endereco_regd, dado_escrita
    );
endinterface

// File: rtl/unidade_muldiv.sv
// Iterative RV32M multiply/divide unit, 32 iterations, fixed 33-edge latency from accept to write.
// The divider datapath is built only when MULDIV_DIVISAO_EN is defined.
module unidade_muldiv (
    input  logic            clock,
    input  logic            reset,
    unidade_muldiv_if.slave bus
);
    typedef enum logic [1:0] {OCIOSO, CALCULA, ESCREVE} estado_t;

    estado_t     estado_q, estado_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] oper_b_q, oper_b_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        ocupado_q, ocupado_d;
    logic        pronto_q, pronto_d;
    logic        reg_escrita_q, reg_escrita_d;
    logic [4:0]  endereco_regd_q, endereco_regd_d;
    logic [31:0] dado_escrita_q, dado_escrita_d;

    logic        assina1, assina2, sinal1, sinal2;
    logic [31:0] mag1, mag2;
    logic [32:0] soma;
    logic [63:0] acc_mul, acc_n, prod_final;
    logic [31:0] resultado;
    logic        escreve_prox;

`ifdef MULDIV_DIVISAO_EN
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [32:0] desloc;
    logic [31:0] subtrai;
    logic        cabe;
    logic [63:0] acc_div;
`endif

    // Operand signedness is decided by funct3 at accept; magnitudes feed both datapaths.
    always_comb begin
        assina1 = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        assina2 = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        sinal1  = assina1 && bus.operando1[31];
        sinal2  = assina2 && bus.operando2[31];
        mag1    = sinal1 ? (32'd0 - bus.operando1) : bus.operando1;
        mag2    = sinal2 ? (32'd0 - bus.operando2) : bus.operando2;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        soma    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, oper_b_q} : 33'd0);
        acc_mul = {soma, acc_q[31:1]};
`ifdef MULDIV_DIVISAO_EN
        desloc  = {acc_q[63:32], acc_q[31]};
        cabe    = desloc >= {1'b0, oper_b_q};
        subtrai = desloc[31:0] - oper_b_q;
        acc_div = cabe ? {subtrai, acc_q[30:0], 1'b1} : {desloc[31:0], acc_q[30:0], 1'b0};
        acc_n   = funct3_q[2] ? acc_div : acc_mul;
`else
        acc_n   = acc_mul;
`endif
    end

    // Result select from the accumulator as it stands after the final iteration.
    always_comb begin
        prod_final = neg_q ? (64'd0 - acc_n) : acc_n;
        resultado  = (funct3_q[1:0] == 2'b00) ? prod_final[31:0] : prod_final[63:32];
`ifdef MULDIV_DIVISAO_EN
        if (funct3_q[2]) begin
            if (funct3_q[1])
                resultado = neg_rem_q ? (32'd0 - acc_n[63:32]) : acc_n[63:32];
            else if (div_zero_q)
                resultado = 32'hFFFF_FFFF;
            else
                resultado = neg_q ? (32'd0 - acc_n[31:0]) : acc_n[31:0];
        end
`else
        if (funct3_q[2])
            resultado = 32'd0;
`endif
    end

    always_comb begin
        estado_d = estado_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        oper_b_d = oper_b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
`ifdef MULDIV_DIVISAO_EN
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (bus.inicio) begin
                    estado_d = CALCULA;
                    funct3_d = bus.funct3;
                    rd_d     = bus.endereco_rd;
                    cnt_d    = 6'd0;
                    neg_d    = sinal1 ^ sinal2;
                    if (bus.funct3[2]) begin
                        oper_b_d = mag2;
                        acc_d    = {32'd0, mag1};
                    end else begin
                        oper_b_d = mag1;
                        acc_d    = {32'd0, mag2};
                    end
`ifdef MULDIV_DIVISAO_EN
                    neg_rem_d  = sinal1;
                    div_zero_d = (bus.operando2 == 32'd0);
`endif
                end
            end
            CALCULA: begin
                acc_d = acc_n;
                cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIVISAO_EN
                if (cnt_q == 6'd31)
                    estado_d = ESCREVE;
`else
                // Without a divider, divide requests leave after a single CALCULA cycle with a zero result.
                if (funct3_q[2] || (cnt_q == 6'd31))
                    estado_d = ESCREVE;
`endif
            end
            ESCREVE: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        escreve_prox    = (estado_d == ESCREVE);
        ocupado_d       = (estado_d != OCIOSO);
        pronto_d        = escreve_prox;
        reg_escrita_d   = escreve_prox && (rd_q != 5'd0);
        endereco_regd_d = escreve_prox ? rd_q : 5'd0;
        dado_escrita_d  = escreve_prox ? resultado : 32'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q        <= OCIOSO;
            funct3_q        <= 3'd0;
            rd_q            <= 5'd0;
            cnt_q           <= 6'd0;
            oper_b_q        <= 32'd0;
            acc_q           <= 64'd0;
            neg_q           <= 1'b0;
            ocupado_q       <= 1'b0;
            pronto_q        <= 1'b0;
            reg_escrita_q   <= 1'b0;
            endereco_regd_q <= 5'd0;
            dado_escrita_q  <= 32'd0;
`ifdef MULDIV_DIVISAO_EN
            neg_rem_q       <= 1'b0;
            div_zero_q      <= 1'b0;
`endif
        end else begin
            estado_q        <= estado_d;
            funct3_q        <= funct3_d;
            rd_q            <= rd_d;
            cnt_q           <= cnt_d;
            oper_b_q        <= oper_b_d;
            acc_q           <= acc_d;
            neg_q           <= neg_d;
            ocupado_q       <= ocupado_d;
            pronto_q        <= pronto_d;
            reg_escrita_q   <= reg_escrita_d;
            endereco_regd_q <= endereco_regd_d;
            dado_escrita_q  <= dado_escrita_d;
`ifdef MULDIV_DIVISAO_EN
            neg_rem_q       <= neg_rem_d;
            div_zero_q      <= div_zero_d;
`endif
        end
    end

    assign bus.ocupado       = ocupado_q;
    assign bus.pronto        = pronto_q;
    assign bus.reg_escrita   = reg_escrita_q;
    assign bus.endereco_regd = endereco_regd_q;
    assign bus.dado_escrita  = dado_escrita_q;
endmodule

// File: tb/tb_unidade_muldiv.sv
// Scoreboard bench for unidade_muldiv: expected write-backs are queued at drive time and
// compared when pronto pulses, including the fixed latency and the idle state afterwards.
module tb_unidade_muldiv;
    logic clock;
    logic reset;

    unidade_muldiv_if bus ();

    unidade_muldiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MULDIV_DIVISAO_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dado;
        int          lat;
    } esperado_t;

    esperado_t fila[$];
    int comparacoes = 0;
    int falhas      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comparacoes++;
        if (obs !== exp) begin
            falhas++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural reference built on native SV arithmetic.
    function automatic logic [31:0] modelo(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (f3[2] && !DIV_EN) return 32'd0;
        case (f3)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int latencia(input logic [2:0] f3);
        return (f3[2] && !DIV_EN) ? 1 : 32;
    endfunction

    // Drives one request for the accept edge and leaves the bench #1 after it.
    task automatic applyStimulus(input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b);
        esperado_t e;
        @(negedge clock);
        bus.funct3      = f3;
        bus.endereco_rd = rd;
        bus.operando1   = a;
        bus.operando2   = b;
        bus.inicio      = 1'b1;
        e.rd   = rd;
        e.dado = modelo(f3, a, b);
        e.lat  = latencia(f3);
        fila.push_back(e);
        @(posedge clock);
        #1;
        bus.inicio = 1'b0;
        checkOutput("ocupado_aceite", {31'd0, bus.ocupado}, 32'd1);
    endtask

    // Called #1 after the accept edge; counts edges until pronto and checks the write-back.
    task automatic waitResult();
        esperado_t e;
        int n = 0;
        while (!bus.pronto && n < 64) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (fila.size() == 0) begin
            checkOutput("fila_vazia", 32'd0, 32'd1);
        end else begin
            e = fila.pop_front();
            if (!bus.pronto) begin
                checkOutput("timeout_pronto", 32'd0, 32'd1);
            end else begin
                checkOutput("dado_escrita", bus.dado_escrita, e.dado);
                checkOutput("endereco_regd", {27'd0, bus.endereco_regd}, {27'd0, e.rd});
                checkOutput("reg_escrita", {31'd0, bus.reg_escrita}, {31'd0, (e.rd != 5'd0)});
                checkOutput("ocupado_escreve", {31'd0, bus.ocupado}, 32'd1);
                checkOutput("latencia", n, e.lat);
            end
        end
    endtask

    task automatic checkIdle();
        @(posedge clock);
        #1;
        checkOutput("ocioso_ocupado", {31'd0, bus.ocupado}, 32'd0);
        checkOutput("ocioso_pronto", {31'd0, bus.pronto}, 32'd0);
        checkOutput("ocioso_reg_escrita", {31'd0, bus.reg_escrita}, 32'd0);
        checkOutput("ocioso_dado", bus.dado_escrita, 32'd0);
        checkOutput("ocioso_endereco", {27'd0, bus.endereco_regd}, 32'd0);
    endtask

    task automatic runOp(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        applyStimulus(f3, rd, a, b);
        waitResult();
        checkIdle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        esperado_t e;
        int pulsos;
        logic [2:0]  f3r;
        logic [4:0]  rdr;
        logic [31:0] ar, br;

        reset           = 1'b1;
        bus.inicio      = 1'b0;
        bus.funct3      = 3'd0;
        bus.endereco_rd = 5'd0;
        bus.operando1   = 32'd0;
        bus.operando2   = 32'd0;
        repeat (2) @(negedge clock);
        checkOutput("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        checkOutput("reset_pronto", {31'd0, bus.pronto}, 32'd0);
        checkOutput("reset_reg_escrita", {31'd0, bus.reg_escrita}, 32'd0);
        checkOutput("reset_endereco", {27'd0, bus.endereco_regd}, 32'd0);
        checkOutput("reset_dado", bus.dado_escrita, 32'd0);
        reset = 1'b0;

        $display("[TB] directed operations");
        runOp(3'b000, 5'd5,  32'd7,          32'hFFFF_FFFD);
        runOp(3'b011, 5'd1,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        runOp(3'b001, 5'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        runOp(3'b010, 5'd3,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        runOp(3'b100, 5'd4,  32'hFFFF_FFF9,  32'd2);
        runOp(3'b110, 5'd6,  32'hFFFF_FFF9,  32'd2);
        runOp(3'b101, 5'd7,  32'h64,         32'd0);
        runOp(3'b111, 5'd8,  32'h64,         32'd0);
        runOp(3'b100, 5'd9,  32'h8000_0000,  32'hFFFF_FFFF);
        runOp(3'b110, 5'd10, 32'h8000_0000,  32'hFFFF_FFFF);
        runOp(3'b100, 5'd11, 32'hFFFF_FFF9,  32'd0);
        runOp(3'b110, 5'd12, 32'hFFFF_FFF9,  32'd0);
        runOp(3'b000, 5'd0,  32'd6,          32'd9);

        $display("[TB] random operations");
        for (int i = 0; i < 10; i++) begin
            f3r = 3'($urandom_range(0, 7));
            rdr = 5'($urandom_range(1, 31));
            ar  = $urandom;
            br  = $urandom;
            runOp(f3r, rdr, ar, br);
        end

        $display("[TB] inicio held high across an operation");
        applyStimulus(3'b000, 5'd7, 32'd3, 32'd5);
        bus.inicio = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        bus.endereco_rd = 5'd8;
        bus.operando1   = 32'd11;
        bus.operando2   = 32'd13;
        e.rd   = 5'd8;
        e.dado = modelo(3'b000, 32'd11, 32'd13);
        e.lat  = latencia(3'b000);
        fila.push_back(e);
        // Counts resume from E4 here, so the first result arrives 28 edges later.
        fila[0].lat = 28;
        waitResult();
        @(posedge clock);
        #1;
        checkOutput("held_ocupado_e33", {31'd0, bus.ocupado}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("held_aceite_e34", {31'd0, bus.ocupado}, 32'd1);
        bus.inicio = 1'b0;
        waitResult();
        checkIdle();

        $display("[TB] reset during CALCULA");
        applyStimulus(3'b000, 5'd9, 32'd21, 32'd2);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_ocupado", {31'd0, bus.ocupado}, 32'd0);
        checkOutput("abort_pronto", {31'd0, bus.pronto}, 32'd0);
        checkOutput("abort_reg_escrita", {31'd0, bus.reg_escrita}, 32'd0);
        checkOutput("abort_dado", bus.dado_escrita, 32'd0);
        void'(fila.pop_back());
        @(negedge clock);
        reset  = 1'b0;
        pulsos = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.pronto || bus.reg_escrita) pulsos++;
        end
        checkOutput("abort_sem_escrita", pulsos, 32'd0);

        runOp(3'b011, 5'd31, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("fila_final", fila.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", comparacoes, falhas);
        $finish;
    end
endmodule

// File: doc/unidade_muldiv.md
# unidade_muldiv

Iterative RV32M multiply/divide unit sitting between the register file's read ports and its write port. It consumes the two source-register values (`valor_reg1`, `valor_reg2`), computes one of the eight M-extension operations over a fixed 32-iteration schedule, and drives the register file's write interface (`reg_escrita`, `endereco_regd`, `dado_escrita`) for exactly one cycle when the result is ready. The unit handles one operation at a time and signals `ocupado` to stall the issuing stage.

## Interface
- No parameters. Data width is fixed at 32 bits and the register address is fixed at 5 bits.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inicio` in 1: request strobe. Sampled only while `ocupado`=0.
- `funct3` in 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `endereco_rd` in 5: destination register of the request.
- `operando1` in 32: rs1 value (`valor_reg1`).
- `operando2` in 32: rs2 value (`valor_reg2`).
- `ocupado` out 1: high from the accept edge until the write cycle ends.
- `pronto` out 1: one-cycle pulse marking the result cycle.
- `reg_escrita` out 1: write enable to the register file.
- `endereco_regd` out 5: write address.
- `dado_escrita` out 32: write data.

## Operation
- **States:** OCIOSO, CALCULA, ESCREVE.
- **OCIOSO:** if `inicio`=1 at an edge, latch `funct3`, `endereco_rd` and both operands, clear the 6-bit iteration counter, and go to CALCULA. Otherwise stay in OCIOSO.
- **CALCULA:** one iteration per edge. After the 32nd iteration, go to ESCREVE.
  - Multiply: shift-add over operand magnitudes into a 64-bit accumulator.
  - Divide: restoring division over magnitudes, producing a 32-bit quotient and a 32-bit remainder.
- **ESCREVE:** drive the result, then return to OCIOSO on the next edge.
- **Signedness:** operands are converted to magnitudes at accept.
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - The final result is negated when the signs require it. For DIV/REM, the quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
- **Result select:**
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- **Divide by zero:** quotient = 0xFFFFFFFF, remainder = dividend, for both signed and unsigned ops.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **Special-case latency:** divide-by-zero and overflow complete with the same fixed latency as normal operations.
- **`endereco_rd`=0:** the operation runs normally and `pronto` pulses, but `reg_escrita` stays 0.
- **`inicio` while `ocupado`=1:** ignored. No queueing, and the latched operands are unaffected.

## Timing
- **Reset values:** state OCIOSO, `ocupado`=0, `pronto`=0, `reg_escrita`=0, `endereco_regd`=0, `dado_escrita`=0, counter=0.
- **Edge numbering:** E0 is the accept edge.
  - `ocupado` rises after E0.
  - Iterations run on E1..E32. ESCREVE is entered at E32.
  - During the cycle after E32, `pronto`=1, `reg_escrita`=1 (unless rd=0), and `endereco_regd`/`dado_escrita` are valid.
  - The register file commits at E33. At E33 the unit returns to OCIOSO with `ocupado`=0.
- **Fixed latency:** 33 edges from accept to write commit, for all operations.
- **Back-to-back:** a new `inicio` can be accepted at E34 at the earliest (the first edge with `ocupado`=0).
- **Outputs:** all registered. `reg_escrita` and `pronto` are exactly one cycle wide. `dado_escrita` and `endereco_regd` return to 0 outside ESCREVE.
- **Reset mid-operation:** aborts immediately to the reset values. No write is issued and the latched request is discarded.

## Configuration
- **`MULDIV_DIVISAO_EN` defined:** all eight operations are implemented as described above.
- **`MULDIV_DIVISAO_EN` not defined:**
  - The divider datapath is not synthesized.
  - Requests with `funct3`[2]=1 are accepted, skip CALCULA, and enter ESCREVE at E1 with `dado_escrita`=0.
  - `reg_escrita` still follows the rd≠0 rule.
  - Multiply operations are unchanged.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5 → `reg_escrita` pulses in the cycle after E32 with `endereco_regd`=5, `dado_escrita`=0xFFFFFFEB, `ocupado` low after E33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 0x64 / 0 → 0xFFFFFFFF. REMU 0x64 / 0 → 0x64.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0. Both use the same 33-edge latency.
- `inicio` held high throughout a MUL with operand changes mid-operation → result reflects only the first request. The second request is accepted at E34.
- Assert `reset` during CALCULA at E10 → outputs 0 immediately and `reg_escrita` never pulses. A request with rd=0 → `pronto` pulses and `reg_escrita` stays 0.
